spi_ctrl: RTL and testbench
===========================

Name: spi_ctrl

Overview:
APB-style register-programmed SPI master. Software loads up to NUM_TXS address/data byte pairs and a control word, then sets start. The block shifts each pair out MSB-first (SPI mode 0) on one of four active-low slave selects. For read-type entries, it captures MISO back into the data register. It sits between the peripheral bus and off-chip SPI slaves.

Parameters:
ADDR_WIDTH, 8, width of paddr_i and of each address register.
DATA_WIDTH, 8, width of pwdata_i/prdata_o, data registers and ctrl register.
NUM_TXS, 8, number of address/data register pairs; legal range 1..16.

Ports:
pclk_i  in  1  clock; all logic on rising edge.
prst_i  in  1  asynchronous reset, active-low (the name is kept; polarity is low-active).
paddr_i  in  ADDR_WIDTH  register address.
pwrite_i  in  1  1 = write, 0 = read.
pwdata_i  in  DATA_WIDTH  write data.
penable_i  in  1  transfer request.
prdata_o  out  DATA_WIDTH  read data.
pready_o  out  1  transfer complete.
perror_o  out  1  transfer error, valid with pready_o.
sclk_o  out  1  SPI clock, idles low.
mosi  out  1  SPI serial out.
miso  in  1  SPI serial in.
ssel  out  4  slave selects, active-low.

Behaviour:
- Reset values (prst_i low): all addr_reg/data_reg/ctrl cleared; sclk_o=0, mosi=0, ssel=4'hF, prdata_o=0, pready_o=0, perror_o=0; FSM returns to IDLE. Reset mid-transfer aborts immediately.
- Register map:
  - 0x00..NUM_TXS-1: addr_reg[i].
  - 0x10..0x10+NUM_TXS-1: data_reg[i].
  - 0x20: ctrl.
  - Any other address is unmapped.
- ctrl fields:
  - [0] start.
  - [3:1] count-1, i.e. pairs 0..count-1 are sent; values above NUM_TXS-1 saturate.
  - [5:4] slave index.
  - [7:6] stored, no function.
- Bus handshake: zero wait state. pready_o = penable_i (combinational).
  - Writes commit at the rising edge where penable_i & pwrite_i are high.
  - prdata_o is a combinational read mux of paddr_i while penable_i & !pwrite_i; otherwise 0.
- perror_o = penable_i & (unmapped address, OR write to addr/data/ctrl while busy). Errored writes do not change state; errored reads return 0.
- Writing ctrl with bit0=1 while IDLE starts a sequence. Hardware clears bit0 when the sequence ends.
- FSM states: IDLE -> SETUP -> ADDR -> DATA -> GAP -> (SETUP for next index | IDLE).
  - SETUP (1 clk): assert ssel[slave]; drive MSB of addr_reg[k] on mosi.
  - ADDR and DATA: 8 bits each, MSB first. Each bit lasts 2 clk: sclk_o high in the 2nd clk.
    - Sample miso at the rising edge of sclk_o.
    - Change mosi after the falling edge.
  - GAP (1 clk): ssel=4'hF, sclk_o=0; then k+1 or finish.
- Read entries: if addr_reg[k][ADDR_WIDTH-1]=1, the 8 bits sampled during DATA overwrite data_reg[k] at the end of DATA. mosi still shifts data_reg[k] out.
- Per-pair latency: 34 clk (1 SETUP + 32 shift + 1 GAP). Sequence of N pairs: 34*N clk from the start write to return to IDLE.
- Only one ssel bit is ever low. sclk_o never toggles while ssel=4'hF.

Optional Feature:
SPI_STATUS_REG_EN:
- Defined: read-only status at 0x21 = {busy, 3'b0, current index k[3:0]}. Writes to 0x21 give perror_o.
- Undefined: 0x21 is unmapped (perror_o on access).

Decomposition:
- Package spi_ctrl_pkg holds: register offsets (ADDR_BASE=0x00, DATA_BASE=0x10, CTRL_ADDR=0x20, STATUS_ADDR=0x21), ctrl bit-field positions, FSM state enum, and constant BIT_CLKS=2.
- One sub-module, spi_shifter: 8-bit shift/sample engine with sclk generation, start/done handshake.
- Register file and FSM stay in spi_ctrl.

Test Plan:
- Reset, then write addr 0x00..0x07 and data 0x10..0x17 with distinct values, write ctrl 0x0E (not started). Read all back -> identical values; pready_o high in the same cycle as penable_i; perror_o=0.
- Access 0x30 (write and read) -> perror_o=1 with pready_o; prdata_o=0; no register changes.
- addr_reg[0]=0x12, data_reg[0]=0xA5, ctrl=0x11 (count 1, slave 1, start) -> ssel=4'b1101 for 32 shift clks; mosi serial stream 0x12A5 MSB first; ssel back to 4'hF; ctrl[0] reads 0 after 34 clk.
- addr_reg[1]=0x80, miso held 1, ctrl=0x03 (two pairs) -> data_reg[1] reads 0xFF afterwards; data_reg[0] unchanged.
- During a busy sequence, write data_reg[2] -> perror_o=1 and value unchanged. Assert prst_i low mid-shift -> ssel=4'hF and sclk_o=0 immediately.
- With SPI_STATUS_REG_EN defined, read 0x21 mid-sequence -> bit7=1 and correct index; after completion -> 0x00.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared constants and types for the spi_ctrl register-programmed SPI master:
// register map offsets, ctrl field positions, FSM states and bit timing.
package spi_ctrl_pkg;

  localparam int unsigned ADDR_BASE   = 'h00;
  localparam int unsigned DATA_BASE   = 'h10;
  localparam int unsigned CTRL_ADDR   = 'h20;
  localparam int unsigned STATUS_ADDR = 'h21;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CNT_LSB   = 1;
  localparam int CTRL_CNT_MSB   = 3;
  localparam int CTRL_SLV_LSB   = 4;
  localparam int CTRL_SLV_MSB   = 5;

  // Clocks per serial bit; sclk is high only in the last one.
  localparam int BIT_CLKS  = 2;
  localparam int BYTE_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ADDR,
    ST_DATA,
    ST_GAP
  } state_e;

  function automatic logic [3:0] ssel_decode(input logic [1:0] slave);
    return ~(4'b0001 << slave);
  endfunction

endpackage

// File: rtl/spi_ctrl_if.sv
// Peripheral-bus side of spi_ctrl: zero-wait-state register access signals.
interface spi_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic                  pwrite_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic                  penable_i;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pready_o;
  logic                  perror_o;

  modport master (
    output paddr_i, pwrite_i, pwdata_i, penable_i,
    input  prdata_o, pready_o, perror_o
  );

  modport slave (
    input  paddr_i, pwrite_i, pwdata_i, penable_i,
    output prdata_o, pready_o, perror_o
  );
endinterface

// File: rtl/spi_ctrl_shifter.sv
// One-byte SPI mode-0 shift/sample engine: generates sclk, shifts MSB first,
// samples miso on sclk rise; done pulses on the final high phase.
module spi_shifter
  import spi_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 preset_i,
  input  logic [BYTE_BITS-1:0] byte_i,
  input  logic                 miso_i,
  output logic                 sclk_o,
  output logic                 mosi_o,
  output logic                 done_o,
  output logic [BYTE_BITS-1:0] rx_o
);

  localparam int PH_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int BW   = $clog2(BYTE_BITS);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BIT_CLKS - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(BYTE_BITS - 1);

  logic                 active_q, active_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [BYTE_BITS-1:0] tx_q, tx_d;
  logic [BYTE_BITS-1:0] rx_q, rx_d;

  assign done_o = active_q && (ph_q == PH_LAST) && (bit_q == BIT_LAST);
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

  // A start coinciding with done chains the next byte with no idle clock.
  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (start_i) begin
      active_d = 1'b1;
      ph_d     = '0;
      bit_d    = '0;
      tx_d     = byte_i;
      mosi_d   = byte_i[BYTE_BITS-1];
      sclk_d   = 1'b0;
    end else if (done_o) begin
      active_d = 1'b0;
      sclk_d   = 1'b0;
      mosi_d   = 1'b0;
      ph_d     = '0;
    end else if (active_q) begin
      ph_d   = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      sclk_d = (ph_d == PH_LAST);
      if (ph_d == PH_LAST) begin
        rx_d = {rx_q[BYTE_BITS-2:0], miso_i};
      end
      if (ph_q == PH_LAST) begin
        tx_d   = tx_q << 1;
        mosi_d = tx_q[BYTE_BITS-2];
        bit_d  = bit_q + 1'b1;
      end
    end else if (preset_i) begin
      mosi_d = byte_i[BYTE_BITS-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ph_q     <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/spi_ctrl.sv
// Register-programmed SPI master: address/data pair registers, ctrl, sequencing FSM.
// Define SPI_STATUS_REG_EN to map the read-only status register at 0x21.
module spi_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TXS    = 8
) (
  input  logic       pclk_i,
  input  logic       prst_i,
  spi_ctrl_if.slave  bus,
  output logic       sclk_o,
  output logic       mosi,
  input  logic       miso,
  output logic [3:0] ssel
);

  localparam int MAX_TXS = 16;
`ifdef SPI_STATUS_REG_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0] addr_q [MAX_TXS];
  logic [ADDR_WIDTH-1:0] addr_d [MAX_TXS];
  logic [DATA_WIDTH-1:0] data_q [MAX_TXS];
  logic [DATA_WIDTH-1:0] data_d [MAX_TXS];
  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  state_e                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [3:0]            ssel_q, ssel_d;

  logic [ADDR_WIDTH-1:0] addr_off, data_off;
  logic                  is_addr, is_data, is_ctrl, is_stat;
  logic                  busy, mapped, err, wr_en, start_req;
  logic [2:0]            cnt_field;
  logic [3:0]            last_k;
  logic [DATA_WIDTH-1:0] rd_val;

  logic                 sh_start, sh_preset, sh_done;
  logic [BYTE_BITS-1:0] sh_byte, sh_rx;

  assign addr_off = bus.paddr_i - ADDR_WIDTH'(ADDR_BASE);
  assign data_off = bus.paddr_i - ADDR_WIDTH'(DATA_BASE);
  assign is_addr  = addr_off < ADDR_WIDTH'(NUM_TXS);
  assign is_data  = data_off < ADDR_WIDTH'(NUM_TXS);
  assign is_ctrl  = bus.paddr_i == ADDR_WIDTH'(CTRL_ADDR);
  assign is_stat  = bus.paddr_i == ADDR_WIDTH'(STATUS_ADDR);

  assign busy   = (state_q != ST_IDLE);
  assign mapped = is_addr | is_data | is_ctrl | (is_stat & STATUS_EN);
  // Registers are frozen while a sequence runs; status is never writable.
  assign err    = bus.penable_i & (~mapped |
                  (bus.pwrite_i & ((busy & (is_addr | is_data | is_ctrl)) | is_stat)));
  assign wr_en     = bus.penable_i & bus.pwrite_i & ~err;
  assign start_req = wr_en & is_ctrl & bus.pwdata_i[CTRL_START_BIT];

  assign cnt_field = ctrl_q[CTRL_CNT_MSB:CTRL_CNT_LSB];
  assign last_k    = ({1'b0, cnt_field} > 4'(NUM_TXS - 1)) ? 4'(NUM_TXS - 1) : {1'b0, cnt_field};

  always_comb begin
    rd_val = '0;
    if (is_addr)      rd_val = DATA_WIDTH'(addr_q[addr_off[3:0]]);
    else if (is_data) rd_val = data_q[data_off[3:0]];
    else if (is_ctrl) rd_val = ctrl_q;
    else if (is_stat) rd_val = DATA_WIDTH'({busy, 3'b000, k_q});
  end

  assign bus.pready_o = bus.penable_i;
  assign bus.perror_o = err;
  assign bus.prdata_o = (bus.penable_i & ~bus.pwrite_i & ~err) ? rd_val : '0;

  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    state_d   = state_q;
    k_d       = k_q;
    ssel_d    = ssel_q;
    sh_start  = 1'b0;
    sh_preset = 1'b0;
    sh_byte   = BYTE_BITS'(addr_q[k_q]);

    if (wr_en) begin
      if (is_addr) addr_d[addr_off[3:0]] = ADDR_WIDTH'(bus.pwdata_i);
      if (is_data) data_d[data_off[3:0]] = bus.pwdata_i;
      if (is_ctrl) ctrl_d = bus.pwdata_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d   = ST_SETUP;
          k_d       = '0;
          ssel_d    = ssel_decode(bus.pwdata_i[CTRL_SLV_MSB:CTRL_SLV_LSB]);
          sh_preset = 1'b1;
          sh_byte   = BYTE_BITS'(addr_q[0]);
        end
      end
      ST_SETUP: begin
        sh_start = 1'b1;
        state_d  = ST_ADDR;
      end
      ST_ADDR: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_byte  = BYTE_BITS'(data_q[k_q]);
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sh_done) begin
          ssel_d  = 4'hF;
          state_d = ST_GAP;
          if (addr_q[k_q][ADDR_WIDTH-1]) data_d[k_q] = DATA_WIDTH'(sh_rx);
        end
      end
      ST_GAP: begin
        if (k_q == last_k) begin
          state_d                = ST_IDLE;
          k_d                    = '0;
          ctrl_d[CTRL_START_BIT] = 1'b0;
        end else begin
          state_d   = ST_SETUP;
          k_d       = k_q + 4'd1;
          ssel_d    = ssel_decode(ctrl_q[CTRL_SLV_MSB:CTRL_SLV_LSB]);
          sh_preset = 1'b1;
          sh_byte   = BYTE_BITS'(addr_q[k_q + 4'd1]);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      ssel_q  <= 4'hF;
      ctrl_q  <= '0;
      for (int i = 0; i < MAX_TXS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ssel_q  <= ssel_d;
      ctrl_q  <= ctrl_d;
      for (int i = 0; i < MAX_TXS; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  spi_shifter u_shifter (
    .clk_i    (pclk_i),
    .rst_ni   (prst_i),
    .start_i  (sh_start),
    .preset_i (sh_preset),
    .byte_i   (sh_byte),
    .miso_i   (miso),
    .sclk_o   (sclk_o),
    .mosi_o   (mosi),
    .done_o   (sh_done),
    .rx_o     (sh_rx)
  );

  assign ssel = ssel_q;

endmodule

// File: tb/tb_spi_ctrl.sv
// Self-checking bench for spi_ctrl: register access, unmapped/busy errors,
// serial stream and read capture against a byte-level model, latency, async reset.
module tb_spi_ctrl;

  localparam int NT = 8;

  logic       pclk_i = 1'b0;
  logic       prst_i;
  logic       sclk_o, mosi, miso;
  logic [3:0] ssel;

  spi_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  spi_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_TXS(NT)) dut (
    .pclk_i (pclk_i),
    .prst_i (prst_i),
    .bus    (bus),
    .sclk_o (sclk_o),
    .mosi   (mosi),
    .miso   (miso),
    .ssel   (ssel)
  );

  always #5 pclk_i = ~pclk_i;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] addr_m [NT];
  logic [7:0] data_m [NT];
  logic [7:0] miso_m [NT];
  logic [7:0] ctrl_m;
  logic [3:0] exp_ssel = 4'hF;
  int         rise_cnt = 0;
  int         mon_base = 0;
  int         sel_errs = 0;
  logic       mosi_bits [$];

  // Slave view: mosi sampled on every sclk rise; select must match the programmed slave.
  always @(posedge sclk_o) begin
    mosi_bits.push_back(mosi);
    if (ssel !== exp_ssel) sel_errs++;
    rise_cnt++;
  end

  // Slave drives one byte per pair during the data phase, MSB first.
  always_comb begin
    int p;
    p = rise_cnt - mon_base;
    miso = 1'b0;
    if (p >= 0 && p < 16 * NT && (p % 16) >= 8) miso = miso_m[p / 16][15 - (p % 16)];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input logic exp_err);
    @(negedge pclk_i);
    bus.paddr_i   = a;
    bus.pwdata_i  = d;
    bus.pwrite_i  = 1'b1;
    bus.penable_i = 1'b1;
    #1;
    check($sformatf("wr_ready_%02h", a), 32'(bus.pready_o), 32'(1));
    check($sformatf("wr_error_%02h", a), 32'(bus.perror_o), 32'(exp_err));
    @(posedge pclk_i);
    #1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    $display("[TB] write addr=%02h data=%02h err=%0b", a, d, bus.perror_o);
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [7:0] exp_d, input logic exp_err);
    @(negedge pclk_i);
    bus.paddr_i   = a;
    bus.pwrite_i  = 1'b0;
    bus.penable_i = 1'b1;
    #1;
    check($sformatf("rd_ready_%02h", a), 32'(bus.pready_o), 32'(1));
    check($sformatf("rd_error_%02h", a), 32'(bus.perror_o), 32'(exp_err));
    check($sformatf("rd_data_%02h", a), 32'(bus.prdata_o), 32'(exp_d));
    $display("[TB] read  addr=%02h data=%02h err=%0b", a, bus.prdata_o, bus.perror_o);
    @(posedge pclk_i);
    #1;
    bus.penable_i = 1'b0;
  endtask

  task automatic write_all();
    for (int i = 0; i < NT; i++) apb_write(8'(i), addr_m[i], 1'b0);
    for (int i = 0; i < NT; i++) apb_write(8'(8'h10 + i), data_m[i], 1'b0);
  endtask

  task automatic run_seq(input logic [7:0] cv);
    int          n, bad, bit0, sel0;
    logic [15:0] w;
    n = int'(cv[3:1]) + 1;
    if (n > NT) n = NT;
    exp_ssel = ~(4'b0001 << cv[5:4]);
    mon_base = rise_cnt;
    bit0     = mosi_bits.size();
    sel0     = sel_errs;
    apb_write(8'h20, cv, 1'b0);
    repeat (34 * n - 1) @(posedge pclk_i);
    #1;
    bus.paddr_i   = 8'h20;
    bus.pwrite_i  = 1'b0;
    bus.penable_i = 1'b1;
    #1;
    check("start_bit_before_34n", 32'(bus.prdata_o[0]), 32'(1));
    @(posedge pclk_i);
    #1;
    check("ctrl_at_34n", 32'(bus.prdata_o), 32'(cv & 8'hFE));
    bus.penable_i = 1'b0;
    check("ssel_after_seq", 32'(ssel), 32'(4'hF));
    check("sclk_after_seq", 32'(sclk_o), 32'(0));
    check("shift_count", 32'(mosi_bits.size() - bit0), 32'(16 * n));
    bad = 0;
    for (int k = 0; k < n; k++) begin
      w = {addr_m[k], data_m[k]};
      for (int b = 0; b < 16; b++) begin
        if (bit0 + 16 * k + b < mosi_bits.size())
          if (mosi_bits[bit0 + 16 * k + b] !== w[15 - b]) bad++;
      end
    end
    check("mosi_stream", 32'(bad), 32'(0));
    check("ssel_during_shift", 32'(sel_errs - sel0), 32'(0));
    for (int k = 0; k < n; k++) if (addr_m[k][7]) data_m[k] = miso_m[k];
    ctrl_m = cv & 8'hFE;
    $display("[TB] sequence ctrl=%02h pairs=%0d bit_errors=%0d", cv, n, bad);
  endtask

  initial begin
    logic [7:0] cv;
    prst_i        = 1'b0;
    bus.paddr_i   = '0;
    bus.pwdata_i  = '0;
    bus.pwrite_i  = 1'b0;
    bus.penable_i = 1'b0;
    for (int i = 0; i < NT; i++) begin
      addr_m[i] = '0; data_m[i] = '0; miso_m[i] = '0;
    end
    ctrl_m = '0;

    // Reset state
    repeat (3) @(posedge pclk_i);
    #1;
    check("rst_ssel", 32'(ssel), 32'(4'hF));
    check("rst_sclk", 32'(sclk_o), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    check("rst_pready", 32'(bus.pready_o), 32'(0));
    check("rst_perror", 32'(bus.perror_o), 32'(0));
    check("rst_prdata", 32'(bus.prdata_o), 32'(0));
    @(negedge pclk_i);
    prst_i = 1'b1;
    apb_read(8'h00, 8'h00, 1'b0);
    apb_read(8'h17, 8'h00, 1'b0);
    apb_read(8'h20, 8'h00, 1'b0);

    // Register write/read-back
    for (int i = 0; i < NT; i++) begin
      addr_m[i] = 8'($urandom);
      data_m[i] = 8'($urandom);
    end
    write_all();
    ctrl_m = 8'h0E;
    apb_write(8'h20, ctrl_m, 1'b0);
    for (int i = 0; i < NT; i++) apb_read(8'(i), addr_m[i], 1'b0);
    for (int i = 0; i < NT; i++) apb_read(8'(8'h10 + i), data_m[i], 1'b0);
    apb_read(8'h20, ctrl_m, 1'b0);

    // Unmapped addresses, including just past each array
    apb_write(8'h30, 8'hFF, 1'b1);
    apb_read(8'h30, 8'h00, 1'b1);
    apb_write(8'h08, 8'hFF, 1'b1);
    apb_read(8'h18, 8'h00, 1'b1);
    apb_read(8'h00, addr_m[0], 1'b0);
    apb_read(8'h20, ctrl_m, 1'b0);
`ifdef SPI_STATUS_REG_EN
    apb_read(8'h21, 8'h00, 1'b0);
    apb_write(8'h21, 8'h55, 1'b1);
`else
    apb_read(8'h21, 8'h00, 1'b1);
    apb_write(8'h21, 8'h55, 1'b1);
`endif

    // Single pair to slave 1
    addr_m[0] = 8'h12;
    data_m[0] = 8'hA5;
    miso_m[0] = 8'($urandom);
    apb_write(8'h00, addr_m[0], 1'b0);
    apb_write(8'h10, data_m[0], 1'b0);
    run_seq(8'h11);
    apb_read(8'h10, data_m[0], 1'b0);

    // Two pairs, second is a read entry with miso high
    addr_m[1] = 8'h80;
    miso_m[1] = 8'hFF;
    apb_write(8'h01, addr_m[1], 1'b0);
    run_seq(8'h03);
    apb_read(8'h10, data_m[0], 1'b0);
    apb_read(8'h11, data_m[1], 1'b0);

    // Randomized sequences
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NT; i++) begin
        addr_m[i] = 8'($urandom);
        data_m[i] = 8'($urandom);
        miso_m[i] = 8'($urandom);
      end
      write_all();
      cv = 8'($urandom) | 8'h01;
      run_seq(cv);
      for (int i = 0; i < NT; i++) apb_read(8'(8'h10 + i), data_m[i], 1'b0);
      apb_read(8'h20, ctrl_m, 1'b0);
    end
`ifdef SPI_STATUS_REG_EN
    apb_read(8'h21, 8'h00, 1'b0);
`endif

    // Busy write rejection, status mid-sequence, async reset mid-shift
    exp_ssel = 4'b1110;
    mon_base = rise_cnt;
    apb_write(8'h20, 8'h03, 1'b0);
    repeat (5) @(posedge pclk_i);
    apb_write(8'h12, ~data_m[2], 1'b1);
    apb_read(8'h12, data_m[2], 1'b0);
`ifdef SPI_STATUS_REG_EN
    repeat (34) @(posedge pclk_i);
    apb_read(8'h21, 8'h81, 1'b0);
`endif
    for (int i = 0; i < 4 && sclk_o !== 1'b1; i++) @(negedge pclk_i);
    check("sclk_high_before_reset", 32'(sclk_o), 32'(1));
    prst_i = 1'b0;
    #1;
    check("reset_ssel", 32'(ssel), 32'(4'hF));
    check("reset_sclk", 32'(sclk_o), 32'(0));
    check("reset_mosi", 32'(mosi), 32'(0));
    repeat (2) @(posedge pclk_i);
    @(negedge pclk_i);
    prst_i = 1'b1;
    apb_read(8'h12, 8'h00, 1'b0);
    apb_read(8'h20, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
